// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer loader: FSM state encoding,
// default framing bytes, header length and the pixel address width helper.
`timescale 1ns/1ps
package fb_pkg;

    // Loader FSM states, in frame order
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_ADR2  = 4'd1,
        ST_ADR1  = 4'd2,
        ST_ADR0  = 4'd3,
        ST_LEN1  = 4'd4,
        ST_LEN0  = 4'd5,
        ST_DATA  = 4'd6,
        ST_SHIFT = 4'd7,
        ST_SKIP  = 4'd8,
        ST_DONE  = 4'd9
    } fb_state_e;

    // Default frame start and acknowledge bytes
    localparam logic [7:0] SYNC_DEF = 8'hAA;
    localparam logic [7:0] ACK_DEF  = 8'h06;

    // SYNC + 3 address bytes + 2 length bytes
    localparam int HDR_LEN = 6;

    // Bits needed to address every pixel of a w x h frame
    function automatic int addr_width(input int w, input int h);
        return $clog2(w * h);
    endfunction

endpackage

// File: rtl/fb_unpack.sv
// Pixel unpacker: loads one byte and emits its 8 bits MSB first on
// consecutive cycles. pix_valid and pix are flop outputs, so they can drive
// the VRAM write port directly. done marks the 8th (last) pixel cycle.
`timescale 1ns/1ps
module fb_unpack (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] din,
    output logic       pix_valid,
    output logic       pix,
    output logic       done
);

    logic [7:0] sr_q, sr_d;
    logic [2:0] cnt_q, cnt_d;
    logic       valid_q, valid_d;

    // Load a fresh byte, otherwise shift one bit out per valid cycle
    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load) begin
            sr_d    = din;
            cnt_d   = 3'd0;
            valid_d = 1'b1;
        end else if (valid_q) begin
            sr_d  = {sr_q[6:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                valid_d = 1'b0;
            end
        end
    end

    // Shift register, bit counter and valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q    <= 8'h00;
            cnt_q   <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign pix_valid = valid_q;
    assign pix       = sr_q[7];
    assign done      = valid_q && (cnt_q == 3'd7);

endmodule

// File: rtl/fb_loader.sv
// Framebuffer loader: parses SYNC / 24-bit address / 16-bit count / data
// frames from the UART receive path and issues one VRAM pixel write per
// cycle, 8 pixels per data byte, MSB first, address wrapping at W*H.
// Optional macro FB_LOADER_ACK_EN: send ACK (or ACK^0x80 on error) on the
// UART transmit side when a frame finishes; otherwise TX outputs are 0.
`timescale 1ns/1ps
module fb_loader
    import fb_pkg::*;
#(
    parameter int         W    = 640,
    parameter int         H    = 480,
    parameter logic [7:0] SYNC = SYNC_DEF,
    parameter logic [7:0] ACK  = ACK_DEF,
    localparam int        AW   = addr_width(W, H)
) (
    input  logic          CLK,
    input  logic          RST_,
    input  logic [7:0]    RX_DATA,
    input  logic          RX_STB,
    output logic          WE,
    output logic [AW-1:0] WADDR,
    output logic          WDATA,
    output logic          BUSY,
    output logic          ERR,
    input  logic          ERR_CLR,
    output logic [7:0]    TX_DATA,
    output logic          TX_STB,
    output logic [3:0]    DBG_STATE
);

    localparam logic [AW:0]   NPIX_EXT = (AW + 1)'(W * H);
    localparam logic [AW-1:0] LAST_PIX = AW'(W * H - 1);

    fb_state_e     state_q, state_d;

    // Holding register handshake: RX_STB is a one-cycle "valid" with no
    // ready; the byte lands in hold_q and sets hold_full_q. The FSM raises
    // consume when it takes the byte. A strobe that finds the register
    // full and not being consumed that cycle is dropped and flags ERR.
    logic [7:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          consume;
    logic          overrun;

    logic [AW-1:0] hdr_addr_q, hdr_addr_d;
    logic [7:0]    len_hi_q, len_hi_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          addr_err;
    logic [15:0]   len_full;

    logic          unp_load;
    logic          unp_valid;
    logic          unp_pix;
    logic          unp_done;

    fb_unpack u_unpack (
        .clk       (CLK),
        .rst_n     (RST_),
        .load      (unp_load),
        .din       (hold_q),
        .pix_valid (unp_valid),
        .pix       (unp_pix),
        .done      (unp_done)
    );

    assign len_full = {len_hi_q, hold_q};

    // Holding register: load on strobe, free on consume, drop on overrun
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        overrun     = 1'b0;
        if (consume) begin
            hold_full_d = 1'b0;
        end
        if (RX_STB) begin
            if (hold_full_q && !consume) begin
                overrun = 1'b1;
            end else begin
                hold_d      = RX_DATA;
                hold_full_d = 1'b1;
            end
        end
    end

    // Frame FSM: header capture, address check, data/skip byte accounting
    always_comb begin
        state_d    = state_q;
        consume    = 1'b0;
        unp_load   = 1'b0;
        hdr_addr_d = hdr_addr_q;
        len_hi_d   = len_hi_q;
        cnt_d      = cnt_q;
        waddr_d    = waddr_q;
        addr_err   = 1'b0;

        // Each written pixel advances the address, wrapping at the frame end
        if (unp_valid) begin
            waddr_d = (waddr_q == LAST_PIX) ? '0 : waddr_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    consume = 1'b1;
                    if (hold_q == SYNC) begin
                        state_d = ST_ADR2;
                    end
                end
            end
            ST_ADR2, ST_ADR1, ST_ADR0: begin
                if (hold_full_q) begin
                    consume = 1'b1;
                    // Address bits above AW fall off the top of the shift
                    hdr_addr_d = AW'({hdr_addr_q, hold_q});
                    case (state_q)
                        ST_ADR2: state_d = ST_ADR1;
                        ST_ADR1: state_d = ST_ADR0;
                        default: state_d = ST_LEN1;
                    endcase
                end
            end
            ST_LEN1: begin
                if (hold_full_q) begin
                    consume  = 1'b1;
                    len_hi_d = hold_q;
                    state_d  = ST_LEN0;
                end
            end
            ST_LEN0: begin
                if (hold_full_q) begin
                    consume = 1'b1;
                    cnt_d   = len_full;
                    if ({1'b0, hdr_addr_q} >= NPIX_EXT) begin
                        addr_err = 1'b1;
                        state_d  = ST_SKIP;
                    end else if (len_full == 16'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        waddr_d = hdr_addr_q;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (hold_full_q) begin
                    consume  = 1'b1;
                    unp_load = 1'b1;
                    if (cnt_q != 16'd0) begin
                        cnt_d = cnt_q - 16'd1;
                    end
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (unp_done) begin
                    state_d = (cnt_q != 16'd0) ? ST_DATA : ST_DONE;
                end
            end
            ST_SKIP: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_DONE;
                end else if (hold_full_q) begin
                    consume = 1'b1;
                    cnt_d   = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky error and busy flag; a new error beats a same-cycle clear
    always_comb begin
        err_d = err_q;
        if (ERR_CLR) begin
            err_d = 1'b0;
        end
        if (overrun || addr_err) begin
            err_d = 1'b1;
        end
        busy_d = !((state_d == ST_IDLE) || (state_d == ST_DONE));
    end

    // Loader state, holding register, header and counter registers
    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            state_q     <= ST_IDLE;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            hdr_addr_q  <= '0;
            len_hi_q    <= 8'h00;
            cnt_q       <= 16'd0;
            waddr_q     <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            hdr_addr_q  <= hdr_addr_d;
            len_hi_q    <= len_hi_d;
            cnt_q       <= cnt_d;
            waddr_q     <= waddr_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

`ifdef FB_LOADER_ACK_EN
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_stb_q, tx_stb_d;

    // Acknowledge is registered so it appears exactly on the DONE cycle
    always_comb begin
        tx_stb_d  = (state_d == ST_DONE);
        tx_data_d = 8'h00;
        if (tx_stb_d) begin
            tx_data_d = err_d ? (ACK ^ 8'h80) : ACK;
        end
    end

    // Acknowledge byte and strobe registers
    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            tx_data_q <= 8'h00;
            tx_stb_q  <= 1'b0;
        end else begin
            tx_data_q <= tx_data_d;
            tx_stb_q  <= tx_stb_d;
        end
    end

    assign TX_DATA = tx_data_q;
    assign TX_STB  = tx_stb_q;
`else
    // No acknowledge path: transmit side held at zero
    assign TX_DATA = ACK & 8'h00;
    assign TX_STB  = 1'b0;
`endif

    assign WE        = unp_valid;
    assign WDATA     = unp_pix;
    assign WADDR     = waddr_q;
    assign BUSY      = busy_q;
    assign ERR       = err_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_fb_loader.sv
// Testbench for fb_loader: directed frames, a frame-level pixel model feeding
// an expected write queue, a per-cycle write checker and an ack checker.
`timescale 1ns/1ps
module tb_fb_loader;

    localparam int AW   = 19;
    localparam int NPIX = 640 * 480;

    // ---------------- clock / reset ----------------
    logic          CLK = 1'b0;
    logic          RST_;
    logic [7:0]    RX_DATA;
    logic          RX_STB;
    logic          WE;
    logic [AW-1:0] WADDR;
    logic          WDATA;
    logic          BUSY;
    logic          ERR;
    logic          ERR_CLR;
    logic [7:0]    TX_DATA;
    logic          TX_STB;
    logic [3:0]    DBG_STATE;

    always #5 CLK = ~CLK;

    fb_loader dut (
        .CLK       (CLK),
        .RST_      (RST_),
        .RX_DATA   (RX_DATA),
        .RX_STB    (RX_STB),
        .WE        (WE),
        .WADDR     (WADDR),
        .WDATA     (WDATA),
        .BUSY      (BUSY),
        .ERR       (ERR),
        .ERR_CLR   (ERR_CLR),
        .TX_DATA   (TX_DATA),
        .TX_STB    (TX_STB),
        .DBG_STATE (DBG_STATE)
    );

    // ---------------- scoreboard ----------------
    int            tests = 0;
    int            fails = 0;
    logic [AW:0]   exp_q[$];
    logic [7:0]    exp_tx[$];
    logic [7:0]    tx_got[$];
    logic [AW:0]   e;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Model: a data byte becomes 8 pixel writes, MSB first, address mod W*H
    task automatic model_byte(inout int addr, input logic [7:0] b);
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back({AW'(addr), b[7-k]});
            addr = (addr + 1) % NPIX;
        end
    endtask

    task automatic expect_ack(input logic [7:0] v);
`ifdef FB_LOADER_ACK_EN
        exp_tx.push_back(v);
`else
        if (v == 8'hFF) exp_tx.push_back(v);  // never true; no acks expected
`endif
    endtask

    // Per-cycle checker: every WE must match the next modelled write
    always @(negedge CLK) begin
        if (RST_) begin
            if (WE) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL we_unexpected got addr=%0d data=%0b exp no write", WADDR, WDATA);
                end else begin
                    e = exp_q.pop_front();
                    if ({WADDR, WDATA} !== e) begin
                        fails++;
                        $display("FAIL pixel got addr=%0d data=%0b exp addr=%0d data=%0b",
                                 WADDR, WDATA, e[AW:1], e[0]);
                    end
                end
            end
            if (TX_STB) tx_got.push_back(TX_DATA);
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; strobe is high for exactly one rising edge
    task automatic send_byte(input logic [7:0] b);
        RX_DATA = b;
        RX_STB  = 1'b1;
        @(negedge CLK);
        RX_STB  = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b);
        send_byte(b);
        repeat (3) @(negedge CLK);
    endtask

    task automatic send_hdr(input logic [23:0] a, input logic [15:0] n);
        send_gap(8'hAA);
        send_gap(a[23:16]);
        send_gap(a[15:8]);
        send_gap(a[7:0]);
        send_gap(n[15:8]);
        send_gap(n[7:0]);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (BUSY && n < 300) begin
            @(negedge CLK);
            n++;
        end
        check(name, {31'd0, BUSY}, 32'd0);
        repeat (3) @(negedge CLK);
    endtask

    task automatic clear_err();
        ERR_CLR = 1'b1;
        @(negedge CLK);
        ERR_CLR = 1'b0;
        check("err_clr", {31'd0, ERR}, 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {WE, WDATA, BUSY, ERR, TX_STB, TX_DATA, 13'd0, WADDR[5:0]}, 32'd0);
        check({name, "_waddr"}, {13'd0, WADDR}, 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int a;
        RST_    = 1'b0;
        RX_STB  = 1'b0;
        RX_DATA = 8'h00;
        ERR_CLR = 1'b0;
        repeat (3) @(negedge CLK);
        check_all_zero("reset_state");
        RST_ = 1'b1;
        repeat (2) @(negedge CLK);

        // Scenario 1: AA 00 00 00 00 01 C3
        send_hdr(24'h000000, 16'd1);
        a = 0;
        model_byte(a, 8'hC3);
        check("model_s1_p0", {12'd0, exp_q[0]}, {12'd0, 19'd0, 1'b1});
        check("model_s1_p2", {12'd0, exp_q[2]}, {12'd0, 19'd2, 1'b0});
        check("model_s1_p7", {12'd0, exp_q[7]}, {12'd0, 19'd7, 1'b1});
        send_byte(8'hC3);
        check("s1_no_we_t1", {31'd0, WE}, 32'd0);
        @(negedge CLK);
        check("s1_first_we", {WE, WDATA, 11'd0, WADDR}, {1'b1, 1'b1, 11'd0, 19'd0});
        repeat (7) @(negedge CLK);
        check("s1_last_we", {WE, BUSY, 11'd0, WADDR}, {1'b1, 1'b1, 11'd0, 19'd7});
        @(negedge CLK);
        check("s1_busy_fall", {30'd0, WE, BUSY}, 32'd0);
        expect_ack(8'h06);
        wait_idle("s1_idle");
        check("s1_drain", exp_q.size(), 32'd0);

        // Scenario 2: start at W*H-1, wrap to 0
        send_hdr(24'h04AFFF, 16'd1);
        a = 307199;
        model_byte(a, 8'hFF);
        check("model_s2_p0", {12'd0, exp_q[0]}, {12'd0, 19'd307199, 1'b1});
        check("model_s2_p1", {12'd0, exp_q[1]}, {12'd0, 19'd0, 1'b1});
        check("model_s2_p7", {12'd0, exp_q[7]}, {12'd0, 19'd6, 1'b1});
        send_byte(8'hFF);
        expect_ack(8'h06);
        wait_idle("s2_idle");
        check("s2_drain", exp_q.size(), 32'd0);
        check("s2_no_err", {31'd0, ERR}, 32'd0);

        // Scenario 3: bad address, two bytes skipped
        send_hdr(24'h050000, 16'd2);
        send_gap(8'h12);
        send_byte(8'h34);
        expect_ack(8'h86);
        wait_idle("s3_idle");
        check("s3_err", {31'd0, ERR}, 32'd1);
        clear_err();

        // Scenario 3b: bad address with N=0 while ERR_CLR hits the same cycle
        send_gap(8'hAA);
        send_gap(8'h05);
        send_gap(8'h00);
        send_gap(8'h00);
        send_gap(8'h00);
        send_byte(8'h00);
        ERR_CLR = 1'b1;
        @(negedge CLK);
        ERR_CLR = 1'b0;
        check("s3b_err_wins", {31'd0, ERR}, 32'd1);
        expect_ack(8'h86);
        wait_idle("s3b_idle");
        clear_err();

        // Scenario 3c: good address, N=0 -> no writes
        send_hdr(24'h000010, 16'd0);
        expect_ack(8'h06);
        wait_idle("s3c_idle");
        check("s3c_no_err", {31'd0, ERR}, 32'd0);

        // Scenario 4: overrun while holding register full during SHIFT
        send_hdr(24'd100, 16'd3);
        a = 100;
        model_byte(a, 8'hA5);
        model_byte(a, 8'h3C);
        model_byte(a, 8'h81);
        send_byte(8'hA5);
        send_byte(8'h3C);
        repeat (2) @(negedge CLK);
        check("s4_err_before", {31'd0, ERR}, 32'd0);
        send_byte(8'hFF);
        check("s4_overrun_err", {31'd0, ERR}, 32'd1);
        repeat (20) @(negedge CLK);
        check("s4_busy_mid", {31'd0, BUSY}, 32'd1);
        send_byte(8'h81);
        expect_ack(8'h86);
        wait_idle("s4_idle");
        check("s4_drain", exp_q.size(), 32'd0);
        clear_err();

        // Scenario 5: reset during the 4th write of scenario 1
        send_hdr(24'h000000, 16'd1);
        a = 0;
        model_byte(a, 8'hC3);
        send_byte(8'hC3);
        repeat (4) @(negedge CLK);
        check("s5_we4", {WE, 12'd0, WADDR}, {1'b1, 12'd0, 19'd3});
        #2;
        RST_ = 1'b0;
        exp_q.delete();
        #1;
        check_all_zero("s5_async_reset");
        @(negedge CLK);
        RST_ = 1'b1;
        repeat (2) @(negedge CLK);
        send_hdr(24'd8, 16'd1);
        a = 8;
        model_byte(a, 8'h5A);
        send_byte(8'h5A);
        expect_ack(8'h06);
        wait_idle("s5_idle");
        check("s5_drain", exp_q.size(), 32'd0);

        // Acknowledge stream
        repeat (3) @(negedge CLK);
        check("tx_count", tx_got.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < tx_got.size(); i++) begin
            check("tx_byte", {24'd0, tx_got[i]}, {24'd0, exp_tx[i]});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
